// File: rtl/stickman_pkg.sv
// Shared types and constants for the stickman game video path.
package stickman_pkg;

   localparam int DEFAULT_COLOR_W = 8;

   // One-hot game status encodings
   localparam logic [3:0] ST_WAIT = 4'b1000;
   localparam logic [3:0] ST_PLAY = 4'b0100;
   localparam logic [3:0] ST_WIN  = 4'b0010;
   localparam logic [3:0] ST_LOSE = 4'b0001;

   typedef enum logic {
      STEADY = 1'b0,
      FADE   = 1'b1
   } fade_state_t;

   typedef struct packed {
      logic [DEFAULT_COLOR_W-1:0] r;
      logic [DEFAULT_COLOR_W-1:0] g;
      logic [DEFAULT_COLOR_W-1:0] b;
   } rgb_t;

endpackage

// File: rtl/layer_color_mapper_fade_scaler.sv
// Fade-in controller and output stage: tracks status changes, ramps a
// per-frame brightness level and scales the stage-1 colour by it.
module fade_scaler
   import stickman_pkg::*;
#(
   parameter int COLOR_W   = DEFAULT_COLOR_W,
   parameter int FADE_LOG2 = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [3:0]             status_i,
   input  logic                   frame_tick_i,
   input  logic [3*COLOR_W-1:0]   color_i,
   input  logic                   blank_i,
   output logic [3*COLOR_W-1:0]   color_o,
   output logic                   fade_active_o
);

   localparam int LVL_W  = FADE_LOG2 + 1;
   localparam int PROD_W = COLOR_W + FADE_LOG2 + 1;
   localparam logic [LVL_W-1:0] FULL = LVL_W'(2 ** FADE_LOG2);
   localparam logic [LVL_W-1:0] LAST = LVL_W'(2 ** FADE_LOG2 - 1);

   fade_state_t            state_q;
   logic [LVL_W-1:0]       level_q;
   logic [3:0]             status_q;
   logic                   status_change;
   logic [3*COLOR_W-1:0]   scaled_d;
   logic [3*COLOR_W-1:0]   color_q;

   assign status_change = (status_i != status_q);

   // Fade FSM: a status change always restarts the ramp, even on a tick
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= FADE;
         level_q  <= '0;
         status_q <= '0;
      end else begin
         status_q <= status_i;
         if (status_change) begin
            level_q <= '0;
            state_q <= FADE;
         end else begin
            case (state_q)
               FADE: begin
                  if (frame_tick_i) begin
                     level_q <= level_q + 1'b1;
                     if (level_q == LAST) begin
                        state_q <= STEADY;
                     end
                  end
               end
               STEADY: level_q <= FULL;
            endcase
         end
      end
   end

   // Per-channel scale: full level is 2**FADE_LOG2, so the shift returns c exactly
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_ch
         logic [PROD_W-1:0] prod;
         assign prod = PROD_W'(color_i[gi*COLOR_W +: COLOR_W]) * PROD_W'(level_q);
         assign scaled_d[gi*COLOR_W +: COLOR_W] = COLOR_W'(prod >> FADE_LOG2);
      end
   endgenerate

   // Stage 2: registered, blanked output
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         color_q <= '0;
      end else begin
         color_q <= blank_i ? scaled_d : '0;
      end
   end

   assign color_o       = color_q;
   assign fade_active_o = (state_q == FADE);

endmodule

// File: rtl/layer_color_mapper.sv
// Pixel colour mapper: resolves prioritised sprite layers over a gradient
// background, picks full-screen colours for non-playing states, then fades.
module layer_color_mapper
   import stickman_pkg::*;
#(
   parameter int NUM_LAYERS = 5,
   parameter int COLOR_W    = DEFAULT_COLOR_W,
   parameter int FADE_LOG2  = 4,
   parameter logic [COLOR_W-1:0] BG_R = COLOR_W'(8'h4f),
   parameter logic [COLOR_W-1:0] BG_G = COLOR_W'(8'h4f),
   parameter logic [COLOR_W-1:0] BG_B = COLOR_W'(8'h7f)
) (
   input  logic                              Clk,
   input  logic                              Reset,
   input  logic [3:0]                        status,
   input  logic [NUM_LAYERS-1:0]             layer_hit,
   input  logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb,
   input  logic [9:0]                        DrawX,
   input  logic [9:0]                        DrawY,
   input  logic                              blank_n,
   input  logic                              frame_tick,
   output logic [COLOR_W-1:0]                VGA_R,
   output logic [COLOR_W-1:0]                VGA_G,
   output logic [COLOR_W-1:0]                VGA_B,
   output logic                              fade_active
);

   localparam int PIX_W = 3 * COLOR_W;
   localparam logic [COLOR_W-1:0] ZERO = '0;
   localparam logic [COLOR_W-1:0] HALF = COLOR_W'(8'h80);

   logic [PIX_W-1:0]   layer_c [NUM_LAYERS];
   logic [PIX_W-1:0]   layer_pix;
   logic [COLOR_W-1:0] bg_b;
   logic [PIX_W-1:0]   sel_d;
   logic [PIX_W-1:0]   color_q;
   logic               blank_q;
   logic [PIX_W-1:0]   pix_out;
   logic               unused_pix;

   // Vertical position and sub-8-pixel x do not affect the colour
   assign unused_pix = &{1'b0, DrawY, DrawX[2:0]};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
         assign layer_c[gi] = layer_rgb[gi*PIX_W +: PIX_W];
      end
   endgenerate

   // Lowest-index hit wins: scan high to low so lower indices overwrite
   always_comb begin
      layer_pix = '0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (layer_hit[i]) begin
            layer_pix = layer_c[i];
         end
      end
   end

   // Horizontal gradient darkens blue by one step every 8 pixels
   assign bg_b = BG_B - COLOR_W'({1'b0, DrawX[9:3]});

   // Colour selection by game status; illegal status values render black
   always_comb begin
      sel_d = '0;
      case (status)
         ST_WAIT: sel_d = {ZERO, ZERO, HALF};
         ST_WIN:  sel_d = {HALF, ZERO, ZERO};
         ST_LOSE: sel_d = {ZERO, HALF, ZERO};
         ST_PLAY: sel_d = (|layer_hit) ? layer_pix : {BG_R, BG_G, bg_b};
         default: sel_d = '0;
      endcase
   end

   // Stage 1: register the selected colour and the blanking flag
   always_ff @(posedge Clk) begin
      if (Reset) begin
         color_q <= '0;
         blank_q <= 1'b0;
      end else begin
         color_q <= sel_d;
         blank_q <= blank_n;
      end
   end

   fade_scaler #(
      .COLOR_W   (COLOR_W),
      .FADE_LOG2 (FADE_LOG2)
   ) u_fade (
      .clk_i         (Clk),
      .rst_i         (Reset),
      .status_i      (status),
      .frame_tick_i  (frame_tick),
      .color_i       (color_q),
      .blank_i       (blank_q),
      .color_o       (pix_out),
      .fade_active_o (fade_active)
   );

   assign VGA_R = pix_out[2*COLOR_W +: COLOR_W];
   assign VGA_G = pix_out[COLOR_W +: COLOR_W];
   assign VGA_B = pix_out[0 +: COLOR_W];

endmodule

// File: tb/tb_layer_color_mapper.sv
// Directed bench for layer_color_mapper with an expected-output queue.
module tb_layer_color_mapper;
   import stickman_pkg::*;

   logic          Clk;
   logic          Reset;
   logic [3:0]    status;
   logic [4:0]    layer_hit;
   logic [119:0]  layer_rgb;
   logic [9:0]    DrawX;
   logic [9:0]    DrawY;
   logic          blank_n;
   logic          frame_tick;
   logic [7:0]    VGA_R;
   logic [7:0]    VGA_G;
   logic [7:0]    VGA_B;
   logic          fade_active;

   typedef struct {
      int          due;
      logic [23:0] rgb;
      string       tag;
   } sb_t;

   sb_t sb[$];
   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;

   layer_color_mapper dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .status      (status),
      .layer_hit   (layer_hit),
      .layer_rgb   (layer_rgb),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .blank_n     (blank_n),
      .frame_tick  (frame_tick),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B),
      .fade_active (fade_active)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Compare every queued expectation whose output cycle has arrived
   task automatic drain();
      sb_t e;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         chk({8'h00, VGA_R, VGA_G, VGA_B}, {8'h00, e.rgb}, e.tag);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         drain();
      end
   endtask

   // Output for inputs driven now appears two edges later
   task automatic expect_rgb(input logic [23:0] v, input string tag);
      sb_t e;
      e.due = cyc + 2;
      e.rgb = v;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         step(1);
         frame_tick = 1'b0;
         step(1);
      end
   endtask

   task automatic set_layer(input int i, input logic [23:0] v);
      layer_rgb[i*24 +: 24] = v;
   endtask

   initial begin
      Reset      = 1'b1;
      status     = 4'b0000;
      layer_hit  = '0;
      layer_rgb  = '0;
      DrawX      = '0;
      DrawY      = 10'd100;
      blank_n    = 1'b0;
      frame_tick = 1'b0;
      set_layer(0, 24'habcdef);
      set_layer(1, 24'hffff00);
      set_layer(2, 24'h000000);
      set_layer(3, 24'h111111);
      set_layer(4, 24'h123456);

      // Reset state
      step(2);
      chk({8'h00, VGA_R, VGA_G, VGA_B}, 32'h0, "reset_rgb");
      chk({31'h0, fade_active}, 32'h1, "reset_fade_active");

      // 1: playing background fades in over 16 ticks
      Reset   = 1'b0;
      status  = ST_PLAY;
      DrawX   = 10'd80;
      blank_n = 1'b1;
      step(2);
      ticks(8);
      chk({31'h0, fade_active}, 32'h1, "bg_mid_fade_active");
      expect_rgb(24'h27273a, "bg_level8");
      step(3);
      ticks(8);
      chk({31'h0, fade_active}, 32'h0, "bg_steady_fade_active");
      expect_rgb(24'h4f4f75, "bg_full");
      step(3);

      // Gradient boundaries, streamed back to back
      DrawX = 10'd0;
      expect_rgb(24'h4f4f7f, "bg_x0");
      step(1);
      DrawX = 10'd1023;
      expect_rgb(24'h4f4f00, "bg_x1023");
      step(1);

      // 2: layer priority, streamed
      layer_hit = 5'b10110;
      expect_rgb(24'hffff00, "prio_10110");
      step(1);
      layer_hit = 5'b11000;
      expect_rgb(24'h111111, "prio_11000");
      step(1);
      layer_hit = 5'b11111;
      expect_rgb(24'habcdef, "prio_11111");
      step(1);
      layer_hit = 5'b10000;
      expect_rgb(24'h123456, "prio_10000");
      step(3);
      chk({31'h0, fade_active}, 32'h0, "prio_no_fade");

      // 3: switch to win, fade restarts
      layer_hit = '0;
      status    = ST_WIN;
      step(1);
      chk({31'h0, fade_active}, 32'h1, "win_fade_active");
      expect_rgb(24'h000000, "win_level0");
      step(3);
      ticks(8);
      expect_rgb(24'h400000, "win_level8");
      step(3);
      ticks(8);
      chk({31'h0, fade_active}, 32'h0, "win_steady_fade_active");
      expect_rgb(24'h800000, "win_full");
      step(3);

      // 4: change coinciding with frame_tick at level 5
      status = ST_LOSE;
      step(2);
      ticks(5);
      expect_rgb(24'h002800, "lose_level5");
      step(3);
      status     = ST_WIN;
      frame_tick = 1'b1;
      expect_rgb(24'h000000, "chg_tick_red");
      step(1);
      frame_tick = 1'b0;
      chk({31'h0, fade_active}, 32'h1, "chg_tick_fade_active");
      step(3);
      ticks(16);
      expect_rgb(24'h800000, "win_full_again");
      step(3);

      // 5: multi-hot and zero status render black, each restarts the fade
      status = 4'b0110;
      step(1);
      chk({31'h0, fade_active}, 32'h1, "multihot_fade_active");
      ticks(16);
      chk({31'h0, fade_active}, 32'h0, "multihot_steady");
      expect_rgb(24'h000000, "multihot_black");
      step(3);
      status = 4'b0000;
      step(1);
      chk({31'h0, fade_active}, 32'h1, "zero_fade_active");
      ticks(16);
      expect_rgb(24'h000000, "zero_black");
      step(3);
      status = ST_WAIT;
      step(2);
      ticks(16);
      expect_rgb(24'h000080, "wait_full");
      step(3);

      // 6: blanking and mid-frame reset
      status = ST_PLAY;
      step(2);
      ticks(16);
      layer_hit = 5'b00001;
      blank_n   = 1'b0;
      expect_rgb(24'h000000, "blank_hit");
      step(1);
      blank_n = 1'b1;
      expect_rgb(24'habcdef, "unblank_hit");
      step(3);
      Reset = 1'b1;
      step(1);
      chk({8'h00, VGA_R, VGA_G, VGA_B}, 32'h0, "midframe_reset_rgb");
      chk({31'h0, fade_active}, 32'h1, "midframe_reset_fade");
      Reset = 1'b0;
      step(2);
      expect_rgb(24'h000000, "post_reset_level0");
      step(3);
      ticks(1);
      expect_rgb(24'h0a0c0e, "post_reset_level1");
      step(4);

      chk(sb.size(), 32'h0, "sb_drained");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/layer_color_mapper.md
Name: layer_color_mapper

Overview:
Parametrised successor to the single-stage colour mapper. Resolves N priority-ordered sprite layers over a gradient background. Selects full-screen colours for the non-playing game states. Adds a 2-stage registered pipeline and a per-frame fade-in whenever the game status changes. It sits between the sprite/hit-test logic and the VGA output pins, clocked by the pixel clock.

Parameters:
NUM_LAYERS, 5, number of sprite layers; index 0 has the highest priority
COLOR_W, 8, bits per colour channel
FADE_LOG2, 4, fade runs over 2**FADE_LOG2 frames
BG_R, 8'h4f, background red
BG_G, 8'h4f, background green
BG_B, 8'h7f, background blue base before the gradient is subtracted

Ports:
Clk  in  1  pixel clock
Reset  in  1  synchronous, active-high
status  in  4  one-hot game status {waiting, playing, win, lose}
layer_hit  in  NUM_LAYERS  bit i is 1 when the current pixel belongs to layer i
layer_rgb  in  NUM_LAYERS*3*COLOR_W  per-layer colour {R,G,B}; layer i sits at slice i
DrawX  in  10  current pixel x
DrawY  in  10  current pixel y
blank_n  in  1  1 = active video
frame_tick  in  1  single-cycle pulse, once per frame
VGA_R  out  COLOR_W  red, registered
VGA_G  out  COLOR_W  green, registered
VGA_B  out  COLOR_W  blue, registered
fade_active  out  1  1 while the fade level is below full

Behaviour:
- One clock (Clk). Reset is synchronous and active-high.
- On reset: VGA_R/G/B = 0, fade_active = 1, fade level = 0, state = FADE, status_q = 4'b0000. The screen fades in after power-up.
- Stage 1 (cycle N+1) registers the selected colour and blank_n:
  - status 4'b1000 (waiting): {0x00, 0x00, 0x80}
  - status 4'b0010 (win): {0x80, 0x00, 0x00}
  - status 4'b0001 (lose): {0x00, 0x80, 0x00}
  - status 4'b0100 (playing):
    - lowest set index i of layer_hit gives layer_rgb[i]
    - if no bit is set: {BG_R, BG_G, BG_B - {1'b0, DrawX[9:3]}}, computed modulo 2**COLOR_W
  - any other status value, including 0 or multi-hot: {0, 0, 0}
- Stage 2 (cycle N+2) produces the outputs:
  - each channel = (c * level) >> FADE_LOG2, with level in 0..2**FADE_LOG2
  - the product is COLOR_W+FADE_LOG2+1 bits wide
  - at full level the output equals c exactly
  - if the stage-1 blank_n is 0, outputs are 0
- Total latency is 2 cycles. The caller delays sync signals to match.
- Fade FSM:
  - status_q registers status every cycle. A change is status != status_q.
  - States are STEADY and FADE.
  - FADE: level increments by 1 on each frame_tick. When it reaches 2**FADE_LOG2, go to STEADY.
  - STEADY: level holds at 2**FADE_LOG2.
  - Change in any state: level = 0, go to FADE.
  - A change and frame_tick in the same cycle: the change wins and level = 0.
  - A change mid-fade restarts the fade from 0.
  - fade_active = (state == FADE).
- Level is applied at the stage-2 register, so a level update takes effect one cycle after it is computed. Mid-frame updates are allowed.
- Reset asserted mid-frame clears both pipeline stages on the next edge.

Decomposition:
- The shared package (stickman_pkg) holds:
  - status one-hot localparams ST_WAIT, ST_PLAY, ST_WIN, ST_LOSE
  - fade_state_t enum {STEADY, FADE}
  - an rgb_t struct with three COLOR_W fields, with COLOR_W as a package constant default
- One sub-module, fade_scaler, holds the level register, the FSM and the per-channel multiply-shift. The top module holds priority selection and stage 1.

Test Plan:
1. Reset for 2 cycles, then status = 4'b0100, no hits, DrawX = 80, blank_n = 1, and 16 frame_ticks -> after the fade completes, output = {0x4f, 0x4f, 0x75}, fade_active = 0.
2. Steady playing, layer_hit = 5'b10110, layer_rgb[1] = {0xff, 0xff, 0x00}, layer_rgb[2] = {0, 0, 0} -> two cycles later output = {0xff, 0xff, 0x00}, because layer 1 wins over layers 2 and 4.
3. Steady playing, switch status to 4'b0010 -> fade_active = 1 the next cycle. After 8 ticks, output = {0x40, 0x00, 0x00}. After 16 ticks, output = {0x80, 0x00, 0x00} and fade_active = 0.
4. Status change in the same cycle as frame_tick while level = 5 -> level = 0 and the output red channel goes to 0.
5. status = 4'b0110 and then 4'b0000 -> output {0, 0, 0}. Each change restarts the fade.
6. blank_n = 0 with a valid layer hit -> output {0, 0, 0} two cycles later. Reset asserted mid-frame -> outputs 0 on the next edge and level = 0.
